// File: rtl/mux_tree_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined mux tree.
// Provides the tree-sizing functions and the per-stage sideband payload.
package mux_pkg;

   // Widest select the sideband can carry (up to 65536 lanes)
   localparam int unsigned SB_SEL_W = 16;

   // Sideband travelling alongside each beat's data through the tree
   typedef struct packed {
      logic                valid;
      logic [SB_SEL_W-1:0] sel;  // select bits not yet consumed, LSB next
      logic                err;
   } sb_t;

   // ceil(log2(n)), but never less than 1
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned tree_levels(input int unsigned n);
      return clog2_min1(n);
   endfunction

   function automatic int unsigned padded_lanes(input int unsigned n);
      return 32'(64'd1 << clog2_min1(n));
   endfunction

   // Lane offset of level l's input inside the flattened tree vector
   function automatic int unsigned lvl_off(input int unsigned pad, input int unsigned l);
      return 2 * (pad - (pad >> l));
   endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Handshake bus for mux_tree_pipe.
// master: lane source + result sink (drives in_*, out_ready)
// slave : the mux tree (drives in_ready, out_*, err_count)
interface mux_tree_pipe_if import mux_pkg::*; #(
   parameter int unsigned N_IN   = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = clog2_min1(N_IN),
   parameter int unsigned CNT_W  = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [N_IN*DATA_W-1:0] in_data;
   logic [SEL_W-1:0]       in_sel;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_data;
   logic                   out_sel_err;
   logic [CNT_W-1:0]       err_count;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_sel_err, err_count
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_sel_err, err_count
   );
endinterface

// File: rtl/mux_tree_stage.sv
// One level of the mux tree: halves the lane count using the next select
// bit, then registers the result with a valid/ready pipeline stage.
// Ports: i_data/i_sb upstream beat, o_rdy_c upstream ready (combinational),
//        o_data/o_sb registered beat, i_rdy downstream ready.
module mux_tree_stage import mux_pkg::*; #(
   parameter int unsigned LANES_IN  = 2,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned SEL_REM_W = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [LANES_IN*DATA_W-1:0]       i_data,
   input  sb_t                              i_sb,
   output logic                             o_rdy_c,
   output logic [(LANES_IN/2)*DATA_W-1:0]   o_data,
   output sb_t                              o_sb,
   input  logic                             i_rdy
);
   localparam int unsigned LANES_OUT = LANES_IN / 2;
   // Keeps only the select bits later levels still need
   localparam logic [SB_SEL_W-1:0] NEXT_SEL_MASK =
      SB_SEL_W'((64'd1 << (SEL_REM_W - 1)) - 64'd1);

   logic [LANES_OUT*DATA_W-1:0] w_mux;
   logic [LANES_OUT*DATA_W-1:0] r_data;
   sb_t                         r_sb;

   // Stage can take a beat when empty or when its beat leaves this cycle
   assign o_rdy_c = !r_sb.valid || i_rdy;

   // Pairwise 2:1 reduction on the current select bit
   always_comb begin
      w_mux = '0;
      for (int unsigned k = 0; k < LANES_OUT; k++) begin
         w_mux[k*DATA_W +: DATA_W] = i_sb.sel[0] ? i_data[(2*k+1)*DATA_W +: DATA_W]
                                                 : i_data[(2*k)*DATA_W +: DATA_W];
      end
   end

   // Payload only loads with a real beat, so idle inputs never disturb state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb   <= '0;
         r_data <= '0;
      end else if (o_rdy_c) begin
         r_sb.valid <= i_sb.valid;
         if (i_sb.valid) begin
            r_sb.sel <= (i_sb.sel >> 1) & NEXT_SEL_MASK;
            r_sb.err <= i_sb.err;
            r_data   <= w_mux;
         end
      end
   end

   assign o_data = r_data;
   assign o_sb   = r_sb;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 lane selector built from registered 2:1 levels.
// Ports: clk, rst (async, active-high); bus (slave modport) carrying the
//        in_* beat with select, the out_* result with select-error flag,
//        and the saturating out-of-range select counter err_count.
module mux_tree_pipe import mux_pkg::*; #(
   parameter int unsigned N_IN   = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = clog2_min1(N_IN),
   parameter int unsigned CNT_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   mux_tree_pipe_if.slave  bus
);
   localparam int unsigned LEVELS = tree_levels(N_IN);
   localparam int unsigned PAD    = padded_lanes(N_IN);
   // Every level's input lanes laid end to end, plus the final single lane
   localparam int unsigned TREE_W = (2*PAD - 1) * DATA_W;

   logic              w_sel_err;
   logic [TREE_W-1:0] w_tree;
   sb_t               w_sb_in;
   sb_t               w_sb [0:LEVELS];
   logic [LEVELS:0]   w_rdy;
   logic [CNT_W-1:0]  r_err_cnt;

   assign w_sel_err = 32'(bus.in_sel) >= N_IN;

   // Zero-pad to a power of two; a bad select zeroes every lane so the
   // tree delivers 0 no matter which path the select bits steer.
   assign w_tree[PAD*DATA_W-1:0] = w_sel_err ? '0 : (PAD*DATA_W)'(bus.in_data);

   always_comb begin
      w_sb_in       = '0;
      w_sb_in.valid = bus.in_valid;
      w_sb_in.sel   = SB_SEL_W'(bus.in_sel);
      w_sb_in.err   = w_sel_err;
   end

   assign w_sb[0]       = w_sb_in;
   assign w_rdy[LEVELS] = bus.out_ready;

   // Level l consumes select bit l (LSB first)
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int unsigned LIN    = PAD >> l;
      localparam int unsigned IN_LO  = lvl_off(PAD, l) * DATA_W;
      localparam int unsigned OUT_LO = lvl_off(PAD, l + 1) * DATA_W;

      mux_tree_stage #(
         .LANES_IN  (LIN),
         .DATA_W    (DATA_W),
         .SEL_REM_W (LEVELS - l)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_data  (w_tree[IN_LO +: LIN*DATA_W]),
         .i_sb    (w_sb[l]),
         .o_rdy_c (w_rdy[l]),
         .o_data  (w_tree[OUT_LO +: (LIN/2)*DATA_W]),
         .o_sb    (w_sb[l+1]),
         .i_rdy   (w_rdy[l+1])
      );
   end

   // Saturating count of accepted beats with an out-of-range select
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (bus.in_valid && w_rdy[0] && w_sel_err && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready    = w_rdy[0];
   assign bus.out_valid   = w_sb[LEVELS].valid;
   assign bus.out_sel_err = w_sb[LEVELS].err;
   assign bus.out_data    = w_tree[TREE_W-1 -: DATA_W];
   assign bus.err_count   = r_err_cnt;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: DUT 0 is 8 lanes / 8-bit counter, DUT 1 is
// 6 lanes / 2-bit counter. A queue-based model tracks beats in flight.
module tb_mux_tree_pipe;
   localparam int unsigned LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_tree_pipe_if #(.N_IN(8), .DATA_W(8), .SEL_W(3), .CNT_W(8)) ifa ();
   mux_tree_pipe_if #(.N_IN(6), .DATA_W(8), .SEL_W(3), .CNT_W(2)) ifb ();

   mux_tree_pipe #(.N_IN(8), .DATA_W(8), .SEL_W(3), .CNT_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .bus(ifa.slave));
   mux_tree_pipe #(.N_IN(6), .DATA_W(8), .SEL_W(3), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .bus(ifb.slave));

   // Per-DUT stimulus and observed outputs
   logic        iv   [2];
   logic        ordy [2];
   logic [2:0]  isel [2];
   logic [63:0] idat [2];
   logic        ir   [2];
   logic        ov   [2];
   logic [7:0]  od   [2];
   logic        oe   [2];
   logic [7:0]  ec   [2];

   assign ifa.in_valid  = iv[0];
   assign ifa.in_sel    = isel[0];
   assign ifa.in_data   = idat[0];
   assign ifa.out_ready = ordy[0];
   assign ifb.in_valid  = iv[1];
   assign ifb.in_sel    = isel[1];
   assign ifb.in_data   = idat[1][47:0];
   assign ifb.out_ready = ordy[1];
   assign ir[0] = ifa.in_ready;  assign ir[1] = ifb.in_ready;
   assign ov[0] = ifa.out_valid; assign ov[1] = ifb.out_valid;
   assign od[0] = ifa.out_data;  assign od[1] = ifb.out_data;
   assign oe[0] = ifa.out_sel_err; assign oe[1] = ifb.out_sel_err;
   assign ec[0] = ifa.err_count; assign ec[1] = 8'(ifb.err_count);

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: beats accepted but not yet delivered, in order.
   // Entry = {accept cycle, 23'b0, err, data}
   int unsigned nin [2] = '{8, 6};
   int unsigned sat [2] = '{255, 3};
   logic [63:0] q0 [$];
   logic [63:0] q1 [$];
   int unsigned errs     [2] = '{0, 0};
   logic        stall_pv [2] = '{1'b0, 1'b0};
   logic [8:0]  held     [2];
   int unsigned idle_run [2] = '{0, 0};
   int unsigned cyc = 0;
   bit          chk_lat = 1'b0;

   function automatic int unsigned qsize(input int d);
      return (d == 0) ? 32'(q0.size()) : 32'(q1.size());
   endfunction

   task automatic mon(input int d);
      int unsigned occ;
      logic        mrdy;
      logic        err;
      logic [7:0]  lane;
      logic [63:0] e;
      logic [63:0] dv;
      if (rst) begin
         if (d == 0) q0.delete(); else q1.delete();
         errs[d] = 0; stall_pv[d] = 1'b0; idle_run[d] = 0;
         return;
      end
      occ  = qsize(d);
      // Stalls only when every stage holds a beat and the sink refuses
      mrdy = ordy[d] || (occ < LAT);
      check($sformatf("dut%0d in_ready", d), 64'(ir[d]), 64'(mrdy));
      check($sformatf("dut%0d err_count", d), 64'(ec[d]),
            64'((errs[d] < sat[d]) ? errs[d] : sat[d]));
      if (stall_pv[d]) begin
         check($sformatf("dut%0d stall valid", d), 64'(ov[d]), 64'd1);
         check($sformatf("dut%0d stall hold", d), 64'({oe[d], od[d]}), 64'(held[d]));
      end
      if (ov[d]) begin
         idle_run[d] = 0;
         check($sformatf("dut%0d beat pending", d), 64'(occ > 0), 64'd1);
         if (ordy[d] && occ > 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d out_data", d), 64'(od[d]), 64'(e[7:0]));
            check($sformatf("dut%0d out_sel_err", d), 64'(oe[d]), 64'(e[8]));
            if (chk_lat) check($sformatf("dut%0d latency", d), 64'(cyc - e[63:32]), 64'(LAT));
         end
      end else if (occ > 0) begin
         idle_run[d]++;
         check($sformatf("dut%0d beat stuck", d), 64'(idle_run[d] < LAT), 64'd1);
      end
      stall_pv[d] = ov[d] && !ordy[d];
      held[d]     = {oe[d], od[d]};
      if (iv[d] && mrdy) begin
         err  = 32'(isel[d]) >= nin[d];
         dv   = idat[d];
         lane = err ? 8'h00 : dv[8*int'(isel[d]) +: 8];
         e    = {cyc, 23'd0, err, lane};
         if (d == 0) q0.push_back(e); else q1.push_back(e);
         if (err) errs[d]++;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      mon(0);
      mon(1);
   end

   // Offer one beat (called at posedge+1), hold until accepted, then idle
   task automatic drive(input int d, input logic [2:0] s, input logic [63:0] dv);
      int unsigned k;
      k = 0;
      iv[d] = 1'b1; isel[d] = s; idat[d] = dv;
      do begin
         @(negedge clk);
         k++;
      end while (!ir[d] && k < 100);
      check($sformatf("dut%0d accept", d), 64'(ir[d]), 64'd1);
      @(posedge clk); #1;
      iv[d] = 1'b0; isel[d] = 3'($urandom); idat[d] = {$urandom, $urandom};
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_run(input int d, input int unsigned n);
      repeat (n) begin
         @(posedge clk); #1;
         iv[d]   = ($urandom_range(0, 99) < 60);
         ordy[d] = ($urandom_range(0, 99) < 70);
         isel[d] = 3'($urandom);
         idat[d] = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      iv[d] = 1'b0; ordy[d] = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] lanes_a;
      logic [63:0] lanes_b;
      lanes_a = 64'h1716_1514_1312_1110;
      lanes_b = 64'h0000_2524_2322_2120;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b1; isel[d] = '0; idat[d] = '0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("dut%0d rst out_valid", d), 64'(ov[d]), 64'd0);
         check($sformatf("dut%0d rst out_data", d), 64'(od[d]), 64'd0);
         check($sformatf("dut%0d rst out_sel_err", d), 64'(oe[d]), 64'd0);
         check($sformatf("dut%0d rst err_count", d), 64'(ec[d]), 64'd0);
         check($sformatf("dut%0d rst in_ready", d), 64'(ir[d]), 64'd1);
      end
      @(posedge clk); #3 rst = 1'b0;
      idle(2);

      // Single beat, then a back-to-back sweep of every select
      chk_lat = 1'b1;
      drive(0, 3'd5, lanes_a);
      idle(5);
      for (int i = 0; i < 8; i++) drive(0, 3'(i), lanes_a);
      idle(5);

      // Six beats with the sink stalled for five cycles mid-stream
      chk_lat = 1'b0;
      fork
         for (int i = 0; i < 6; i++) drive(0, 3'(i + 2), lanes_a ^ {8{8'(i * 16)}});
         begin
            idle(2);
            ordy[0] = 1'b0;
            idle(5);
            ordy[0] = 1'b1;
         end
      join
      idle(8);

      // Six-lane DUT: one good select, then five out-of-range ones
      chk_lat = 1'b1;
      drive(1, 3'd5, lanes_b);
      drive(1, 3'd6, lanes_b);
      drive(1, 3'd7, lanes_b);
      drive(1, 3'd6, lanes_b);
      drive(1, 3'd7, lanes_b);
      drive(1, 3'd7, lanes_b);
      idle(5);
      check("dut1 err_count saturated", 64'(ec[1]), 64'd3);

      // Asynchronous reset with three beats in flight in both DUTs
      chk_lat = 1'b0;
      fork
         for (int i = 0; i < 3; i++) drive(0, 3'(i), lanes_a);
         for (int i = 0; i < 3; i++) drive(1, 3'(i + 5), lanes_b);
      join
      check("dut0 pre-reset out_valid", 64'(ov[0]), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("dut0 reset out_valid", 64'(ov[0]), 64'd0);
      check("dut1 reset out_valid", 64'(ov[1]), 64'd0);
      check("dut1 reset err_count", 64'(ec[1]), 64'd0);
      @(posedge clk); #3 rst = 1'b0;
      idle(4);
      chk_lat = 1'b1;
      drive(0, 3'd6, lanes_a);
      idle(5);

      // Random traffic and backpressure on both DUTs, then drain
      chk_lat = 1'b0;
      fork
         rand_run(0, 1500);
         rand_run(1, 1500);
      join
      idle(10);
      check("dut0 drained", 64'(qsize(0)), 64'd0);
      check("dut1 drained", 64'(qsize(1)), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
